// File: rtl/hl2link_pkg.sv
// hl2link_pkg: shared state encoding, tuser codes and payload width for the hl2link send path
package hl2link_pkg;
  localparam int PAYLOAD_W = 38;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] TUSER_CMD = 2'b01;
  localparam logic [1:0] TUSER_SMP = 2'b10;
endpackage

// File: rtl/hl2link_arb_pri.sv
// hl2link_arb_pri: command-over-sample priority with a starvation guard for pending samples
module hl2link_arb_pri #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic cmd_valid,
  input  logic smp_valid,
  input  logic master_sel,
  output logic grant_cmd,
  output logic grant_smp
);
  localparam int SW = STARVE_MAX > 0 ? $clog2(STARVE_MAX + 1) : 1;
  logic [SW-1:0] starve_cnt;
  logic smp_elig;
  logic at_max;
  always_comb begin
    smp_elig = smp_valid & ~master_sel;
    at_max = starve_cnt == SW'(STARVE_MAX);
    grant_smp = en & smp_elig & (~cmd_valid | at_max);
    grant_cmd = en & cmd_valid & ~grant_smp;
  end
  always_ff @(posedge clk)
    if (rst || grant_smp) starve_cnt <= '0;
    else if (grant_cmd && smp_elig && !at_max) starve_cnt <= starve_cnt + 1'b1;
endmodule

// File: rtl/hl2link_send_arb.sv
// hl2link_send_arb: arbitrates command and sample requests onto the link send interface
module hl2link_send_arb #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        master_sel,
  input  logic        cmd_valid,
  input  logic [5:0]  cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        cmd_ready,
  output logic        cmd_done,
  input  logic        smp_valid,
  input  logic [23:0] smp_data,
  input  logic [13:0] smp_aux,
  output logic        smp_ready,
  output logic        smp_done,
  output logic        send_tvalid,
  output logic [37:0] send_tdata,
  output logic [1:0]  send_tuser,
  input  logic        send_tready,
  input  logic        send_tdone,
  output logic        xfer_timeout
);
  import hl2link_pkg::*;
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [1:0] state;
  logic [1:0] grant_q;
  logic [1:0] done_q;
  logic [PAYLOAD_W-1:0] data_q;
  logic [TW-1:0] tmo_cnt;
  logic grant_cmd;
  logic grant_smp;
  logic arb_en;
  logic tmo_hit;
  hl2link_arb_pri #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .clk(clk),
    .rst(rst),
    .en(arb_en),
    .cmd_valid(cmd_valid),
    .smp_valid(smp_valid),
    .master_sel(master_sel),
    .grant_cmd(grant_cmd),
    .grant_smp(grant_smp)
  );
  // a completion arriving in the last allowed cycle wins over the abort
  always_comb begin
    arb_en = (state == ST_IDLE) & ~rst;
    tmo_hit = (state != ST_IDLE) & (tmo_cnt == TW'(TIMEOUT - 1)) & ~send_tdone;
    cmd_ready = grant_cmd;
    smp_ready = grant_smp;
    cmd_done = ~rst & done_q[0];
    smp_done = ~rst & done_q[1];
    xfer_timeout = ~rst & tmo_hit;
    send_tvalid = ~rst & (state == ST_SEND) & ~tmo_hit;
    send_tdata = rst ? '0 : data_q;
    send_tuser = rst ? '0 : grant_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= ST_IDLE;
      grant_q <= '0;
      done_q <= '0;
      data_q <= '0;
      tmo_cnt <= '0;
    end else begin
      done_q <= '0;
      if (state == ST_IDLE) begin
        if (grant_cmd || grant_smp) begin
          state <= ST_SEND;
          grant_q <= grant_cmd ? TUSER_CMD : TUSER_SMP;
          data_q <= grant_cmd ? {cmd_addr, cmd_data} : {smp_data, smp_aux};
          tmo_cnt <= '0;
        end
      end else if (send_tdone) begin
        state <= ST_IDLE;
        done_q <= grant_q;
      end else if (tmo_hit) state <= ST_IDLE;
      else begin
        tmo_cnt <= tmo_cnt + 1'b1;
        if (state == ST_SEND && send_tready) state <= ST_WAIT;
      end
    end
endmodule

// File: tb/tb_hl2link_send_arb.sv
// tb_hl2link_send_arb: scenario tasks plus a payload scoreboard for hl2link_send_arb
module tb_hl2link_send_arb;
  import hl2link_pkg::*;
  logic clk = 0;
  logic rst, master_sel, cmd_valid, smp_valid, send_tready, send_tdone;
  logic [5:0] cmd_addr;
  logic [31:0] cmd_data;
  logic [23:0] smp_data;
  logic [13:0] smp_aux;
  logic cmd_ready, cmd_done, smp_ready, smp_done, send_tvalid, xfer_timeout;
  logic [37:0] send_tdata;
  logic [1:0] send_tuser;
  int checks = 0, failures = 0;
  int n_cr = 0, n_cd = 0, n_sr = 0, n_sd = 0, n_to = 0;
  logic prev_valid = 0;
  logic [39:0] sb[$];
  logic [39:0] exp_item;
  logic [9:0] order;

  hl2link_send_arb #(.STARVE_MAX(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .master_sel(master_sel),
    .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .cmd_done(cmd_done),
    .smp_valid(smp_valid), .smp_data(smp_data), .smp_aux(smp_aux),
    .smp_ready(smp_ready), .smp_done(smp_done),
    .send_tvalid(send_tvalid), .send_tdata(send_tdata), .send_tuser(send_tuser),
    .send_tready(send_tready), .send_tdone(send_tdone), .xfer_timeout(xfer_timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_ready === 1'b1) n_cr++;
    if (cmd_done === 1'b1) n_cd++;
    if (smp_ready === 1'b1) n_sr++;
    if (smp_done === 1'b1) n_sd++;
    if (xfer_timeout === 1'b1) n_to++;
    if (send_tvalid === 1'b1 && !prev_valid) begin
      order = {order[8:0], send_tuser[1]};
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got=%h expected=none", {send_tuser, send_tdata});
      end else begin
        exp_item = sb.pop_front();
        if ({send_tuser, send_tdata} !== exp_item) begin
          failures++;
          $display("FAIL sb_payload got=%h expected=%h", {send_tuser, send_tdata}, exp_item);
        end
      end
    end
    prev_valid = (send_tvalid === 1'b1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_xfer;
    @(negedge clk);
    for (int i = 0; i < 50 && send_tvalid !== 1'b1; i++) @(negedge clk);
    checks++;
    if (send_tvalid !== 1'b1) begin
      failures++;
      $display("FAIL xfer_wait tvalid=%b expected=1", send_tvalid);
    end
    send_tready = 1;
    send_tdone = 1;
    step;
    send_tready = 0;
    send_tdone = 0;
  endtask

  task automatic test_reset;
    rst = 1; master_sel = 0; cmd_valid = 1; smp_valid = 1;
    send_tready = 0; send_tdone = 0;
    cmd_addr = 6'h3f; cmd_data = 32'hffff_ffff; smp_data = '1; smp_aux = '1;
    repeat (3) step;
    @(negedge clk);
    checks++;
    if ({send_tvalid, cmd_ready, cmd_done, smp_ready, smp_done, xfer_timeout, send_tdata, send_tuser} !== 44'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h expected=0",
               {send_tvalid, cmd_ready, cmd_done, smp_ready, smp_done, xfer_timeout, send_tdata, send_tuser});
    end
    step;
    cmd_valid = 0; smp_valid = 0; rst = 0;
    step;
  endtask

  task automatic test_single_cmd;
    int cr0 = n_cr, cd0 = n_cd;
    cmd_addr = 6'h39; cmd_data = 32'h0000_090d; cmd_valid = 1;
    sb.push_back({TUSER_CMD, 38'h39_0000_090d});
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%b expected=1", cmd_ready); end
    step;
    cmd_valid = 0;
    @(negedge clk);
    checks++;
    if (send_tvalid !== 1'b1) begin failures++; $display("FAIL single_latency got=%b expected=1", send_tvalid); end
    step; send_tready = 1;
    step; send_tready = 0;
    step;
    step; send_tdone = 1;
    step; send_tdone = 0;
    @(negedge clk);
    checks++;
    if (cmd_done !== 1'b1) begin failures++; $display("FAIL single_done got=%b expected=1", cmd_done); end
    repeat (3) step;
    checks++;
    if (n_cr - cr0 != 1 || n_cd - cd0 != 1) begin
      failures++;
      $display("FAIL single_pulses ready=%0d done=%0d expected=1,1", n_cr - cr0, n_cd - cd0);
    end
  endtask

  task automatic test_starvation;
    int cr0 = n_cr, sr0 = n_sr, cd0 = n_cd, sd0 = n_sd;
    cmd_addr = 6'h05; cmd_data = 32'hcafe_0001; smp_data = 24'habcdef; smp_aux = 14'h1234;
    master_sel = 0;
    for (int i = 0; i < 10; i++)
      sb.push_back((i % 5 == 4) ? {TUSER_SMP, smp_data, smp_aux} : {TUSER_CMD, cmd_addr, cmd_data});
    order = '0;
    cmd_valid = 1; smp_valid = 1;
    for (int i = 0; i < 10; i++) do_xfer;
    cmd_valid = 0; smp_valid = 0;
    repeat (2) step;
    checks++;
    if (order !== 10'b0000100001) begin failures++; $display("FAIL starve_order got=%b expected=0000100001", order); end
    checks++;
    if (n_cr - cr0 != 8 || n_sr - sr0 != 2) begin
      failures++;
      $display("FAIL starve_ready cmd=%0d smp=%0d expected=8,2", n_cr - cr0, n_sr - sr0);
    end
    checks++;
    if (n_cd - cd0 != 8 || n_sd - sd0 != 2) begin
      failures++;
      $display("FAIL starve_done cmd=%0d smp=%0d expected=8,2", n_cd - cd0, n_sd - sd0);
    end
  endtask

  task automatic test_master;
    int bad = 0;
    int sd0;
    master_sel = 1; smp_valid = 1; cmd_valid = 0;
    smp_data = 24'h13579b; smp_aux = 14'h2aaa;
    repeat (100) begin
      @(negedge clk);
      if (send_tvalid !== 1'b0 || smp_ready !== 1'b0 || cmd_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL master_blocked bad_cycles=%0d expected=0", bad); end
    step;
    master_sel = 0;
    sb.push_back({TUSER_SMP, 24'h13579b, 14'h2aaa});
    @(negedge clk);
    checks++;
    if (smp_ready !== 1'b1) begin failures++; $display("FAIL master_smp_ready got=%b expected=1", smp_ready); end
    step;
    smp_valid = 0;
    @(negedge clk);
    checks++;
    if (send_tvalid !== 1'b1 || send_tuser !== TUSER_SMP) begin
      failures++;
      $display("FAIL master_smp_tuser valid=%b tuser=%b expected=1,10", send_tvalid, send_tuser);
    end
    sd0 = n_sd;
    do_xfer;
    step;
    checks++;
    if (n_sd - sd0 != 1) begin failures++; $display("FAIL master_smp_done got=%0d expected=1", n_sd - sd0); end
  endtask

  task automatic test_timeout;
    int first = 0, cnt_to = 0, cd0;
    cmd_addr = 6'h2a; cmd_data = 32'h1234_5678; cmd_valid = 1;
    sb.push_back({TUSER_CMD, 6'h2a, 32'h1234_5678});
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL tmo_ready got=%b expected=1", cmd_ready); end
    cd0 = n_cd;
    step;
    cmd_valid = 0; send_tready = 1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (xfer_timeout === 1'b1) begin
        cnt_to++;
        if (first == 0) first = k;
      end
      step;
      if (k == 1) send_tready = 0;
    end
    checks++;
    if (first != 16) begin failures++; $display("FAIL tmo_cycle got=%0d expected=16", first); end
    checks++;
    if (cnt_to != 1) begin failures++; $display("FAIL tmo_pulses got=%0d expected=1", cnt_to); end
    checks++;
    if (n_cd != cd0) begin failures++; $display("FAIL tmo_no_done got=%0d expected=0", n_cd - cd0); end
    cmd_addr = 6'h11; cmd_data = 32'h0bad_f00d; cmd_valid = 1;
    sb.push_back({TUSER_CMD, 6'h11, 32'h0bad_f00d});
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL tmo_next_grant got=%b expected=1", cmd_ready); end
    step;
    cmd_valid = 0;
    do_xfer;
    step;
  endtask

  task automatic test_reset_mid;
    int cd0, to0;
    cmd_addr = 6'h07; cmd_data = 32'h7777_0000; cmd_valid = 1; smp_valid = 1; master_sel = 0;
    sb.push_back({TUSER_CMD, 6'h07, 32'h7777_0000});
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b expected=1", cmd_ready); end
    step;
    cmd_valid = 0; smp_valid = 0; send_tready = 1;
    step;
    send_tready = 0;
    cd0 = n_cd; to0 = n_to;
    rst = 1; send_tdone = 1;
    step;
    rst = 0; send_tdone = 0;
    @(negedge clk);
    checks++;
    if (send_tvalid !== 1'b0 || dut.state !== ST_IDLE) begin
      failures++;
      $display("FAIL rstmid_idle tvalid=%b state=%0d expected=0,0", send_tvalid, dut.state);
    end
    checks++;
    if (dut.u_arb.starve_cnt !== 3'd0) begin
      failures++;
      $display("FAIL rstmid_starve got=%0d expected=0", dut.u_arb.starve_cnt);
    end
    repeat (3) step;
    checks++;
    if (n_cd != cd0 || n_to != to0) begin
      failures++;
      $display("FAIL rstmid_silent done=%0d tmo=%0d expected=0,0", n_cd - cd0, n_to - to0);
    end
  endtask

  task automatic test_same_cycle;
    cmd_addr = 6'h01; cmd_data = 32'h0000_0001; cmd_valid = 1;
    sb.push_back({TUSER_CMD, 6'h01, 32'h0000_0001});
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL same_ready got=%b expected=1", cmd_ready); end
    step;
    cmd_valid = 0; send_tready = 1; send_tdone = 1;
    step;
    send_tready = 0; send_tdone = 0;
    cmd_addr = 6'h22; cmd_data = 32'h2222_2222; cmd_valid = 1;
    sb.push_back({TUSER_CMD, 6'h22, 32'h2222_2222});
    @(negedge clk);
    checks++;
    if (cmd_done !== 1'b1 || dut.state !== ST_IDLE) begin
      failures++;
      $display("FAIL same_done done=%b state=%0d expected=1,0", cmd_done, dut.state);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL same_b2b_ready got=%b expected=1", cmd_ready); end
    step;
    cmd_valid = 0;
    do_xfer;
    step;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_single_cmd;
    test_starvation;
    test_master;
    test_timeout;
    test_reset_mid;
    test_same_cycle;
    repeat (3) step;
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d expected=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
